// File: rtl/rtc_transaction_sequencer_if.sv
// Link between the transaction sequencer and the RTC bus-cycle generator.
// The generator's completion pulse is carried as fin because final is a reserved word.
interface rtc_transaction_sequencer_if;
  logic       iniciar;
  logic       escribe;
  logic [7:0] direccion;
  logic [7:0] dato;
  logic       fin;
  logic       cap;
  logic [7:0] bus_in;

  modport master (
    output iniciar,
    output escribe,
    output direccion,
    output dato,
    input  fin,
    input  cap,
    input  bus_in
  );

  modport slave (
    input  iniciar,
    input  escribe,
    input  direccion,
    input  dato,
    output fin,
    output cap,
    output bus_in
  );
endinterface

// File: rtl/rtc_transaction_sequencer.sv
// Issues six single-register RTC bus cycles (seconds..year) back to back and
// presents either a latched write of all six or an atomically updated read snapshot.
module rtc_transaction_sequencer #(
  parameter logic [7:0]  ADDR_BASE  = 8'h21,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_read,
  input  logic       start_write,
  input  logic [7:0] wr_seg,
  input  logic [7:0] wr_min,
  input  logic [7:0] wr_hora,
  input  logic [7:0] wr_dia,
  input  logic [7:0] wr_mes,
  input  logic [7:0] wr_anio,
  rtc_transaction_sequencer_if.master bus,
  output logic [7:0] rd_seg,
  output logic [7:0] rd_min,
  output logic [7:0] rd_hora,
  output logic [7:0] rd_dia,
  output logic [7:0] rd_mes,
  output logic [7:0] rd_anio,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic       mode_reg;
  logic [2:0] idx_reg;
  logic [3:0] gap_cnt_reg;
  logic [7:0] tmo_cnt_reg;
  logic [7:0] wbuf_reg [6];
  logic [7:0] rbuf_reg [6];
  logic [7:0] rd_reg   [6];
  logic [7:0] wr_arr   [6];

  logic       iniciar_reg;
  logic       escribe_reg;
  logic [7:0] direccion_reg;
  logic [7:0] dato_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       error_reg;

  assign wr_arr[0] = wr_seg;
  assign wr_arr[1] = wr_min;
  assign wr_arr[2] = wr_hora;
  assign wr_arr[3] = wr_dia;
  assign wr_arr[4] = wr_mes;
  assign wr_arr[5] = wr_anio;

  assign rd_seg  = rd_reg[0];
  assign rd_min  = rd_reg[1];
  assign rd_hora = rd_reg[2];
  assign rd_dia  = rd_reg[3];
  assign rd_mes  = rd_reg[4];
  assign rd_anio = rd_reg[5];

  assign bus.iniciar   = iniciar_reg;
  assign bus.escribe   = escribe_reg;
  assign bus.direccion = direccion_reg;
  assign bus.dato      = dato_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      mode_reg      <= 1'b0;
      idx_reg       <= 3'd0;
      gap_cnt_reg   <= 4'd0;
      tmo_cnt_reg   <= 8'd0;
      iniciar_reg   <= 1'b0;
      escribe_reg   <= 1'b0;
      direccion_reg <= 8'h00;
      dato_reg      <= 8'h00;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        wbuf_reg[i] <= 8'h00;
        rbuf_reg[i] <= 8'h00;
        rd_reg[i]   <= 8'h00;
      end
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      // Lags the state by one edge, so busy drops the cycle after done/error.
      busy_reg  <= (state_reg != S_IDLE);

      case (state_reg)
        S_IDLE: begin
          if (start_write) begin
            mode_reg <= 1'b1;
            idx_reg  <= 3'd0;
            for (int i = 0; i < 6; i++) begin
              wbuf_reg[i] <= wr_arr[i];
            end
            state_reg <= S_LOAD;
          end else if (start_read) begin
            mode_reg  <= 1'b0;
            idx_reg   <= 3'd0;
            state_reg <= S_LOAD;
          end
        end

        S_LOAD: begin
          direccion_reg <= ADDR_BASE + 8'(idx_reg);
          dato_reg      <= mode_reg ? wbuf_reg[idx_reg] : 8'h00;
          escribe_reg   <= mode_reg;
          iniciar_reg   <= 1'b1;
          tmo_cnt_reg   <= 8'd0;
          state_reg     <= S_WAIT;
        end

        S_WAIT: begin
          if (!mode_reg && bus.cap) begin
            rbuf_reg[idx_reg] <= bus.bus_in;
          end
          // A completion on the very last allowed cycle still counts as success.
          if (bus.fin) begin
            iniciar_reg <= 1'b0;
            if (idx_reg == 3'd5) begin
              state_reg <= S_DONE;
            end else begin
              idx_reg     <= idx_reg + 3'd1;
              gap_cnt_reg <= GAP_LOAD;
              state_reg   <= S_GAP;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            iniciar_reg <= 1'b0;
            error_reg   <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end

        S_GAP: begin
          if (gap_cnt_reg == 4'd0) begin
            state_reg <= S_LOAD;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end

        S_DONE: begin
          done_reg <= 1'b1;
          if (!mode_reg) begin
            for (int i = 0; i < 6; i++) begin
              rd_reg[i] <= rbuf_reg[i];
            end
          end
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_transaction_sequencer.sv
// Directed bench for rtc_transaction_sequencer with a 29-cycle bus-cycle generator model.
module tb_rtc_transaction_sequencer;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_read = 1'b0;
  logic       start_write = 1'b0;
  logic [7:0] wr_seg = 8'h00, wr_min = 8'h00, wr_hora = 8'h00;
  logic [7:0] wr_dia = 8'h00, wr_mes = 8'h00, wr_anio = 8'h00;
  logic [7:0] rd_seg, rd_min, rd_hora, rd_dia, rd_mes, rd_anio;
  logic       busy, done, error;

  always #5 clk = ~clk;

  rtc_transaction_sequencer_if bus ();

  rtc_transaction_sequencer #(
    .ADDR_BASE  (8'h21),
    .GAP_CYCLES (G),
    .TIMEOUT    (63)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_read  (start_read),
    .start_write (start_write),
    .wr_seg      (wr_seg),
    .wr_min      (wr_min),
    .wr_hora     (wr_hora),
    .wr_dia      (wr_dia),
    .wr_mes      (wr_mes),
    .wr_anio     (wr_anio),
    .bus         (bus),
    .rd_seg      (rd_seg),
    .rd_min      (rd_min),
    .rd_hora     (rd_hora),
    .rd_dia      (rd_dia),
    .rd_mes      (rd_mes),
    .rd_anio     (rd_anio),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  wire [47:0] rd_vec = {rd_seg, rd_min, rd_hora, rd_dia, rd_mes, rd_anio};

  int checks = 0;
  int errors = 0;

  // Generator model and handshake monitor state (updated on negedge only).
  logic [7:0] base_val = 8'h10;
  int         withhold_txn = -1;
  int         cnt = 0;
  int         cyc = 0;
  int         txn_n = 0;
  int         low_run = 1000;
  int         min_low = 1000;
  int         hs_err = 0, fall_err = 0, stable_err = 0;
  int         done_cnt = 0, error_cnt = 0, rd_chg = 0;
  int         rise_cyc = 0, err_cyc = 0;
  logic [7:0] log_dir [8];
  logic [7:0] log_dat [8];
  logic       log_esc [8];
  logic       prev_ini = 1'b0, prev_fin = 1'b0, prev_esc = 1'b0;
  logic [7:0] prev_dir = 8'h00, prev_dat = 8'h00;
  logic [47:0] prev_rd = 48'h0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.iniciar && !prev_ini) begin
      if (prev_fin) hs_err = hs_err + 1;
      if (txn_n < 8) begin
        log_dir[txn_n] = bus.direccion;
        log_dat[txn_n] = bus.dato;
        log_esc[txn_n] = bus.escribe;
      end
      if (low_run < min_low) min_low = low_run;
      txn_n = txn_n + 1;
      rise_cyc = cyc;
    end
    if (bus.iniciar && prev_ini &&
        ({bus.direccion, bus.dato, bus.escribe} != {prev_dir, prev_dat, prev_esc}))
      stable_err = stable_err + 1;
    if (prev_fin && bus.iniciar) fall_err = fall_err + 1;
    if (!bus.iniciar && prev_ini && !prev_fin && !error && !reset) fall_err = fall_err + 1;
    low_run = bus.iniciar ? 0 : low_run + 1;
    if (done) done_cnt = done_cnt + 1;
    if (error) begin
      error_cnt = error_cnt + 1;
      err_cyc = cyc;
    end
    if (rd_vec != prev_rd) rd_chg = rd_chg + 1;
    prev_ini = bus.iniciar;
    prev_dir = bus.direccion;
    prev_dat = bus.dato;
    prev_esc = bus.escribe;
    prev_rd  = rd_vec;
    cnt = bus.iniciar ? cnt + 1 : 0;
    bus.cap    = bus.iniciar && !bus.escribe && (cnt == 26);
    bus.bus_in = base_val + (bus.direccion - 8'h21);
    bus.fin    = (cnt == 29) && ((txn_n - 1) != withhold_txn);
    prev_fin   = bus.fin;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    txn_n = 0; done_cnt = 0; error_cnt = 0; rd_chg = 0; min_low = 1000;
    hs_err = 0; fall_err = 0; stable_err = 0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({bus.iniciar, bus.escribe, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.iniciar, bus.escribe, busy, done, error});
    end
    checks++;
    if ({bus.direccion, bus.dato} !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0000", {bus.direccion, bus.dato});
    end
    checks++;
    if (rd_vec !== 48'h0) begin
      errors++;
      $display("FAIL reset_rd: got %h expected 0", rd_vec);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_all();
    bit ok;
    clear_mon();
    base_val = 8'h10;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL read_busy_rise: got %b expected 1", busy);
    end
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL read_done: got done=%b ok=%0d expected done=1", done, ok);
    end
    checks++;
    if (rd_vec !== 48'h101112131415) begin
      errors++;
      $display("FAIL read_snapshot: got %h expected 101112131415", rd_vec);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_busy_fall: got %b expected 0", busy);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({log_dir[i], log_dat[i], log_esc[i]} !== {8'(8'h21 + i), 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL read_txn%0d: got dir=%h dat=%h esc=%b expected dir=%h dat=00 esc=0",
                 i, log_dir[i], log_dat[i], log_esc[i], 8'(8'h21 + i));
      end
    end
    checks++;
    if (txn_n != 6 || done_cnt != 1 || rd_chg != 1) begin
      errors++;
      $display("FAIL read_counts: got txn=%0d done=%0d rdchg=%0d expected 6 1 1", txn_n, done_cnt, rd_chg);
    end
    $display("read_all: snapshot %h, %0d transactions", rd_vec, txn_n);
  endtask

  task automatic test_write_all();
    bit ok;
    logic [7:0] exp_w [6];
    exp_w = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h16};
    clear_mon();
    {wr_seg, wr_min, wr_hora, wr_dia, wr_mes, wr_anio} = 48'h453012070916;
    start_write = 1'b1;
    step();
    start_write = 1'b0;
    {wr_seg, wr_min, wr_hora, wr_dia, wr_mes, wr_anio} = 48'hEEEEEEEEEEEE;
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL write_done: got done=%b ok=%0d expected done=1", done, ok);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({log_dir[i], log_dat[i], log_esc[i]} !== {8'(8'h21 + i), exp_w[i], 1'b1}) begin
        errors++;
        $display("FAIL write_txn%0d: got dir=%h dat=%h esc=%b expected dir=%h dat=%h esc=1",
                 i, log_dir[i], log_dat[i], log_esc[i], 8'(8'h21 + i), exp_w[i]);
      end
    end
    checks++;
    if (rd_vec !== 48'h101112131415 || done_cnt != 1 || txn_n != 6) begin
      errors++;
      $display("FAIL write_state: got rd=%h done=%0d txn=%0d expected 101112131415 1 6", rd_vec, done_cnt, txn_n);
    end
    $display("write_all: %0d transactions, done count %0d", txn_n, done_cnt);
  endtask

  task automatic test_handshake();
    // Monitor counters accumulate over the preceding write sequence.
    checks++;
    if (hs_err != 0) begin
      errors++;
      $display("FAIL hs_rise_during_final: got %0d expected 0", hs_err);
    end
    checks++;
    if (fall_err != 0) begin
      errors++;
      $display("FAIL hs_fall_timing: got %0d expected 0", fall_err);
    end
    checks++;
    if (stable_err != 0) begin
      errors++;
      $display("FAIL hs_bus_stable: got %0d expected 0", stable_err);
    end
    checks++;
    if (min_low < G + 1) begin
      errors++;
      $display("FAIL hs_gap: got %0d expected >= %0d", min_low, G + 1);
    end
    $display("handshake: min low gap %0d cycles", min_low);
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    base_val = 8'h50;
    withhold_txn = 2;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    wait_end(ok);
    checks++;
    if (!ok || error !== 1'b1 || bus.iniciar !== 1'b0) begin
      errors++;
      $display("FAIL timeout_error: got error=%b iniciar=%b ok=%0d expected 1 0", error, bus.iniciar, ok);
    end
    step();
    withhold_txn = -1;
    checks++;
    if (err_cyc - rise_cyc != 63) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 63", err_cyc - rise_cyc);
    end
    checks++;
    if (busy !== 1'b0 || bus.iniciar !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b iniciar=%b expected 0 0", busy, bus.iniciar);
    end
    checks++;
    if (rd_vec !== 48'h101112131415 || done_cnt != 0 || txn_n != 3 || error_cnt != 1) begin
      errors++;
      $display("FAIL timeout_state: got rd=%h done=%0d txn=%0d err=%0d expected 101112131415 0 3 1",
               rd_vec, done_cnt, txn_n, error_cnt);
    end
    $display("timeout: error after %0d cycles, rd %h", err_cyc - rise_cyc, rd_vec);
  endtask

  task automatic test_simultaneous();
    bit ok;
    clear_mon();
    {wr_seg, wr_min, wr_hora, wr_dia, wr_mes, wr_anio} = 48'hA0A1A2A3A4A5;
    start_read = 1'b1;
    start_write = 1'b1;
    step();
    start_read = 1'b0;
    start_write = 1'b0;
    wait_end(ok);
    step();
    checks++;
    if (!ok || done_cnt != 1 || txn_n != 6) begin
      errors++;
      $display("FAIL simul_done: got ok=%0d done=%0d txn=%0d expected 1 1 6", ok, done_cnt, txn_n);
    end
    checks++;
    if ({log_esc[0], log_esc[5], log_dat[0], log_dat[5]} !== {2'b11, 8'hA0, 8'hA5}) begin
      errors++;
      $display("FAIL simul_write_wins: got esc=%b%b dat=%h,%h expected 11 a0,a5",
               log_esc[0], log_esc[5], log_dat[0], log_dat[5]);
    end
    $display("simultaneous: escribe=%b, %0d transactions", log_esc[0], txn_n);
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_mon();
    base_val = 8'h30;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    repeat (40) step();
    {wr_seg, wr_min, wr_hora, wr_dia, wr_mes, wr_anio} = 48'h999999999999;
    start_read = 1'b1;
    start_write = 1'b1;
    step();
    start_read = 1'b0;
    start_write = 1'b0;
    wait_end(ok);
    repeat (200) step();
    checks++;
    if (!ok || done_cnt != 1 || txn_n != 6) begin
      errors++;
      $display("FAIL busy_ignored: got ok=%0d done=%0d txn=%0d expected 1 1 6", ok, done_cnt, txn_n);
    end
    checks++;
    if (rd_vec !== 48'h303132333435 || log_esc[5] !== 1'b0) begin
      errors++;
      $display("FAIL busy_snapshot: got rd=%h esc=%b expected 303132333435 0", rd_vec, log_esc[5]);
    end
    $display("busy_start: done count %0d, rd %h", done_cnt, rd_vec);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_mon();
    base_val = 8'h70;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (txn_n == 4 && bus.iniciar) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_reach: got txn=%0d expected 4", txn_n);
    end
    repeat (10) step();
    reset = 1'b1;
    step();
    checks++;
    if ({bus.iniciar, busy, done} !== 3'b000 || rd_vec !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid_state: got ini=%b busy=%b done=%b rd=%h expected 000 0",
               bus.iniciar, busy, done, rd_vec);
    end
    step();
    reset = 1'b0;
    repeat (5) step();
    clear_mon();
    base_val = 8'h10;
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    wait_end(ok);
    checks++;
    if (!ok || done !== 1'b1 || rd_vec !== 48'h101112131415) begin
      errors++;
      $display("FAIL reset_mid_recover: got done=%b rd=%h expected 1 101112131415", done, rd_vec);
    end
    step();
    checks++;
    if (txn_n != 6 || fall_err != 0 || stable_err != 0) begin
      errors++;
      $display("FAIL reset_mid_hs: got txn=%0d fall=%0d stable=%0d expected 6 0 0", txn_n, fall_err, stable_err);
    end
    $display("reset_mid: recovered snapshot %h", rd_vec);
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_read_all();
    test_write_all();
    test_handshake();
    test_timeout();
    test_simultaneous();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtc_transaction_sequencer.md
# rtc_transaction_sequencer

Sequences the RTC register transactions for one full time access: six consecutive single-register bus cycles (seconds, minutes, hours, day, month, year) issued to the RTC bus-cycle generator through its `iniciar`/`final` handshake. The block sits directly upstream of the bus-cycle generator. It drives that generator's `direccion`, `dato`, `escribe` and `iniciar` inputs, and collects read bytes using the generator's capture strobe. Toward the application it offers a one-shot read-all / write-all request interface and a coherent six-byte time snapshot.

## Interface
- `ADDR_BASE`, default 8'h21: RTC address of seconds; register i is at ADDR_BASE+i, for i=0..5.
- `GAP_CYCLES`, default 2: idle cycles with `iniciar`=0 between consecutive transactions; legal range 1..15.
- `TIMEOUT`, default 63: maximum cycles spent in WAIT before abort; legal range 32..255.
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high.
- `start_read`, input, 1: pulse; read all six registers.
- `start_write`, input, 1: pulse; write all six registers.
- `wr_seg`, `wr_min`, `wr_hora`, `wr_dia`, `wr_mes`, `wr_anio`, input, 8 each: write values.
- `final`, input, 1: transaction-complete pulse from the bus-cycle generator.
- `cap`, input, 1: read-data-valid strobe from the generator (its `escreg`).
- `bus_in`, input, 8: RTC data bus, sampled when `cap`=1.
- `iniciar`, output, 1: transaction enable to the generator.
- `escribe`, output, 1: 1 = write, 0 = read.
- `direccion`, output, 8: register address.
- `dato`, output, 8: write data.
- `rd_seg`, `rd_min`, `rd_hora`, `rd_dia`, `rd_mes`, `rd_anio`, output, 8 each: last complete read snapshot.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse when the sequence completes successfully.
- `error`, output, 1: one-cycle pulse on timeout abort.

## Operation
- All outputs are registered.
- Reset values: `iniciar`=0, `escribe`=0, `direccion`=0, `dato`=0, `done`=0, `error`=0, all `rd_*`=0. State goes to IDLE, `idx`=0.
- Internal state: 3-bit `idx`; six 8-bit write buffers `wbuf`; six 8-bit read shadows `rbuf`; a gap counter; a timeout counter.
- **IDLE**
  - On `start_write`: set mode=write, copy `wr_*` into `wbuf`, set `idx`=0, go to LOAD.
  - Else on `start_read`: set mode=read, set `idx`=0, go to LOAD.
  - Write wins when both starts are high in the same cycle.
  - Starts arriving in any state other than IDLE are ignored; they are not queued.
- **LOAD**
  - Register `direccion`=ADDR_BASE+`idx`, `dato`=`wbuf[idx]` (0 in read mode), `escribe`=mode, `iniciar`=1.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - `iniciar`, `direccion`, `dato` and `escribe` are held stable.
  - In read mode, when `cap`=1: `rbuf[idx]`<=`bus_in`. If `cap` is high for several cycles, the last sample wins.
  - When `final`=1: `iniciar`<=0. If `idx`==5, go to DONE; otherwise `idx`++, load the gap counter, and go to GAP.
  - When the timeout counter reaches TIMEOUT without `final`: `iniciar`<=0, `error`<=1, go to IDLE.
  - On abort, `rd_*` are left unchanged and `rbuf` contents are discarded.
- **GAP**: count GAP_CYCLES cycles, then go to LOAD. `iniciar` stays 0 so the generator resets its internal counter.
- **DONE**
  - `done`<=1 for one cycle.
  - In read mode, all six `rd_*`<=`rbuf` in the same edge, so the snapshot updates atomically.
  - In write mode, `rd_*` are unchanged.
  - Go to IDLE.
- Address arithmetic is modulo 256: ADDR_BASE=8'hFE wraps to 8'h00..8'h03 for idx 2..5.
- `reset` mid-sequence returns to IDLE on the next edge with reset values. `iniciar` drops immediately, so the generator aborts too.

## Timing
- Start sampled at edge k → LOAD during cycle k+1 → `iniciar`=1 and address valid from edge k+2.
- Bus signals are stable no later than the first cycle `iniciar` is high and remain stable until `iniciar` falls.
- `final` sampled high at edge f → `iniciar`=0 from edge f+1. `iniciar` stays low for GAP_CYCLES+1 cycles before the next transaction.
- With the generator's fixed 29-cycle transaction, total latency from start to `done` is about 6·(29+GAP_CYCLES+2) cycles. This is not a hard requirement; the bench checks ordering and handshake only.
- `busy` rises at edge k+1 and falls the cycle after `done` or `error`.

## Test plan
- **Read all.** Bus model answers address 0x21+i with 0x10+i and `cap` on cycle 26 of each transaction. Pulse `start_read` → `direccion` sequence 0x21..0x26 with `escribe`=0. `done` pulses once, and `rd_seg`..`rd_anio` = 0x10..0x15, all changing in the same cycle.
- **Write all.** `wr_*` = 0x45,0x30,0x12,0x07,0x09,0x16, and `start_write` is pulsed; inputs change the next cycle. Required: each transaction shows the matching `direccion`/`dato` pair from the latched values, `escribe`=1, `rd_*` unchanged, `done` pulses once.
- **Handshake.** `iniciar` never rises while `final`=1. `iniciar` falls exactly one cycle after `final`. There are ≥GAP_CYCLES+1 low cycles between transactions. Bus signals never change while `iniciar`=1.
- **Timeout.** Model withholds `final` on transaction 3 → `error` pulses 63 cycles after `iniciar` rose. `iniciar`=0, `busy`=0, `rd_*` keep their previous snapshot, and `done` never pulses.
- **Simultaneous/busy starts.** `start_read` and `start_write` in the same cycle → write sequence runs. `start_read` during busy → ignored; exactly one `done` results.
- **Reset mid-sequence.** Assert `reset` during transaction 4 → next edge has `iniciar`=0, `busy`=0, `rd_*`=0. A fresh `start_read` then completes normally.
